// File: rtl/debug_display_arbiter.sv
// debug_display_arbiter: shares one 16-bit debug display among NUM_SRC requesters via timed or button-driven selection.
// Optional DEBUG_DISP_SRC_TAG_EN puts the source index on the leftmost digit.
module debug_display_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int DWELL_CYCLES = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  localparam int SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_SRC-1:0]    src_req,
  input  logic [16*NUM_SRC-1:0] src_data,
  output logic [NUM_SRC-1:0]    src_ack,
  input  logic [NUM_SRC-1:0]    src_en,
  input  logic                  mode_auto,
  input  logic                  freeze,
  input  logic                  btn_next,
  output logic [15:0]           number_out,
  output logic                  disp_valid,
  output logic [SW-1:0]         src_sel,
  output logic [NUM_SRC-1:0]    led_out
);
  localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam int BW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  typedef enum logic {WAIT, SHOW} state_t;
  state_t state_q, state_d;
  logic sync1_q, sync2_q, deb_q, deb_d, mode_q;
  logic [BW-1:0] deb_cnt_q, deb_cnt_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [SW-1:0] sel_q, sel_d, next_sel, cand;
  logic [15:0] num_q, num_d;
  logic [NUM_SRC-1:0] ack_q, ack_d;
  logic mism, deb_done, btn_adv, tmr_on, tmr_adv, adv, cap, found;
  always_comb begin
    mism = sync2_q != deb_q;
    deb_done = mism && deb_cnt_q == BW'(DEBOUNCE_CYCLES - 1);
    deb_cnt_d = (mism && !deb_done) ? deb_cnt_q + 1'b1 : '0;
    deb_d = deb_done ? sync2_q : deb_q;
    btn_adv = deb_done && sync2_q;
    tmr_on = mode_auto && !freeze;
    tmr_adv = tmr_on && dwell_q == DW'(DWELL_CYCLES - 1);
    adv = btn_adv || tmr_adv;
    dwell_d = (adv || mode_auto != mode_q) ? '0 : tmr_on ? dwell_q + 1'b1 : dwell_q;
    // first enabled index after the current one; stays put when none other is enabled
    next_sel = sel_q;
    cand = '0;
    found = 1'b0;
    for (int i = 1; i < NUM_SRC; i++) begin
      cand = SW'((int'(sel_q) + i) % NUM_SRC);
      if (!found && src_en[cand]) begin
        next_sel = cand;
        found = 1'b1;
      end
    end
    cap = !adv && !freeze && src_req[sel_q];
    sel_d = adv ? next_sel : sel_q;
    num_d = adv ? '0 : cap ? src_data[{sel_q, 4'b0000} +: 16] : num_q;
    ack_d = cap ? NUM_SRC'(1) << sel_q : '0;
    state_d = adv ? WAIT : cap ? SHOW : state_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q <= 1'b0;
      deb_cnt_q <= '0;
      dwell_q <= '0;
      mode_q <= 1'b0;
      sel_q <= '0;
      num_q <= '0;
      ack_q <= '0;
      state_q <= WAIT;
    end else begin
      sync1_q <= btn_next;
      sync2_q <= sync1_q;
      deb_q <= deb_d;
      deb_cnt_q <= deb_cnt_d;
      dwell_q <= dwell_d;
      mode_q <= mode_auto;
      sel_q <= sel_d;
      num_q <= num_d;
      ack_q <= ack_d;
      state_q <= state_d;
    end
  end
  assign src_ack = ack_q;
  assign src_sel = sel_q;
  assign led_out = NUM_SRC'(1) << sel_q;
  assign disp_valid = state_q == SHOW;
`ifdef DEBUG_DISP_SRC_TAG_EN
  assign number_out = {4'(sel_q), num_q[11:0]};
`else
  assign number_out = num_q;
`endif
endmodule

// File: doc/debug_display_arbiter.md
Name: debug_display_arbiter

Overview:
- Shares the single 16-bit debug 7-segment display between NUM_SRC debug requesters, e.g. CPU PC, PPU scanline, APU state or bus address.
- Selects one source at a time: either round-robin on a dwell timer (auto mode) or by a debounced push button (manual mode).
- Captures the selected source's value with a req/ack handshake and drives the display driver's 16-bit number input, plus one-hot source LEDs.

Parameters:
- NUM_SRC, 4, number of requesters (2..8)
- DWELL_CYCLES, 50_000_000, auto-mode cycles per source
- DEBOUNCE_CYCLES, 1_000_000, cycles the synchronized button must be stable before its debounced state changes

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- src_req  in  NUM_SRC  per-source "new value available"; held high until acked
- src_data  in  16*NUM_SRC  source i's value in bits [16*i+15:16*i]
- src_ack  out  NUM_SRC  one-cycle capture pulse to the selected source
- src_en  in  NUM_SRC  rotation mask; a disabled source is skipped
- mode_auto  in  1  1 = timed rotation, 0 = button only
- freeze  in  1  1 = hold display contents and stop the dwell timer
- btn_next  in  1  raw asynchronous push button, active high
- number_out  out  16  value sent to the display driver
- disp_valid  out  1  number_out holds a capture from the current source
- src_sel  out  max(1,$clog2(NUM_SRC))  current source index
- led_out  out  NUM_SRC  one-hot of src_sel

Behaviour:
- Reset (rst_n low at a clk edge):
  - src_sel=0, led_out=1, number_out=0, disp_valid=0, src_ack=0.
  - Dwell counter, debounce counter, synchronizer and debounced state all 0.
- Button path:
  - 2-flop synchronizer, then a stability counter.
  - The debounced state takes the synchronized value after it differs from the debounced state for DEBOUNCE_CYCLES consecutive cycles. The counter clears on any mismatch break.
  - A rising edge of the debounced state produces a one-cycle btn_adv pulse. This works in both modes and regardless of freeze.
- Timer path:
  - Active only when mode_auto=1 and freeze=0.
  - Dwell counter increments per cycle. At DWELL_CYCLES-1 it produces tmr_adv and wraps to 0.
  - Holds its value while freeze=1.
  - Clears on any advance and on any change of mode_auto.
- Advance (btn_adv or tmr_adv):
  - Next src_sel is the first index after src_sel, wrapping modulo NUM_SRC, with src_en set.
  - If no other source is enabled, src_sel is unchanged but the advance still occurs: disp_valid clears and the counter clears.
  - On the same edge: number_out=0, disp_valid=0, led_out updated.
  - A simultaneous btn_adv and tmr_adv counts as one advance.
- Main FSM:
  - WAIT (disp_valid=0) and SHOW (disp_valid=1).
  - In either state, with no advance this cycle, freeze=0 and src_req[src_sel]=1:
    - On the next edge, number_out = src_data slice of src_sel, src_ack[src_sel]=1 for exactly that one cycle, and the state becomes SHOW.
    - Latency is 1 cycle from req to number_out/ack.
  - After an ack, a request still high is recaptured one cycle later. Requesters drop req upon ack, so the sustained capture rate is one per 2 cycles.
  - Advance → WAIT from any state.
- Boundary rules:
  - Requests from non-selected sources are never acked.
  - Advance and capture in the same cycle: advance wins, no ack is issued, and old data is not captured.
  - freeze=1 blocks captures only; number_out and disp_valid hold.
  - At most one src_ack bit is high in any cycle.
  - src_en[src_sel] going low does not force an advance.
  - Reset mid-handshake drops a pending ack.

Optional Feature:
- Macro DEBUG_DISP_SRC_TAG_EN.
- Defined:
  - number_out[15:12] = src_sel, zero-extended to 4 bits, even when disp_valid=0.
  - number_out[11:0] = captured src_data slice [11:0].
  - The leftmost digit therefore identifies the source.
- Undefined: number_out carries all 16 captured bits; tag logic is absent.

Test Plan (bench params NUM_SRC=4, DWELL_CYCLES=8, DEBOUNCE_CYCLES=4, src_en=4'b1111):
- Reset then mode_auto=0, src_req[0]=1 with data 16'hBEEF:
  - Next cycle: number_out=BEEF, src_ack=4'b0001 for one cycle, disp_valid=1.
  - src_req[2] alone → never acked.
- mode_auto=1, all req low:
  - src_sel steps 0→1→2→3→0, every 8 cycles.
  - led_out steps 0001→0010→0100→1000.
  - number_out=0 after each step.
- btn_next glitch high for 3 cycles:
  - No advance.
- btn_next high for 10 cycles:
  - Exactly one advance, occurring 2+4 cycles after the rise.
  - Dwell counter cleared.
- src_en=4'b1001 with src_sel=0:
  - Advance → src_sel=3, next advance → 0.
- src_en=4'b0001:
  - Advance keeps src_sel=0 and clears disp_valid.
- freeze=1 while src_req[1]=1 and src_sel=1:
  - No ack, number_out holds, timer holds.
  - Release → ack next cycle.
- Advance coinciding with src_req[src_sel]:
  - No ack, number_out=0.
  - With DEBUG_DISP_SRC_TAG_EN and src_sel=2, data 16'h1234 → number_out=16'h2234.
